imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream of the IF stage: fills the 32-bit instruction memory from a byte stream (UART receiver or debug port) before the pipeline runs.
- Holds the CPU in reset (cpu_rst) until a complete, checksum-verified image is written, then releases it so IF starts fetching at PC 0.
- Writes go through the instruction memory's write port: one 32-bit word per write pulse.

Parameters:
- CODE_DIR_WIDTH, 4, instruction memory word-address width.
- CODE_DEPTH, 16, number of instruction words; maximum image length.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000, inter-byte gap limit; used only with BOOT_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  CODE_DIR_WIDTH  word address being written.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  pipeline reset; high until the load succeeds.
- boot_done  out  1  image loaded and verified.
- boot_err  out  1  last frame failed (bad count, bad checksum, or timeout).

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values:
  - rx_ready=1, cpu_rst=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - boot_done=0, boot_err=0.
  - state=IDLE, internal counters and checksum = 0.
- Frame format, in order:
  - SYNC_BYTE.
  - count byte N, word count, legal range 1..CODE_DEPTH.
  - 4N data bytes, big-endian per word (first byte = bits 31:24).
  - checksum byte = 8-bit modulo-256 sum of all 4N data bytes.
- States:
  - IDLE: a byte equal to SYNC_BYTE → COUNT. Other bytes are discarded.
  - COUNT: N==0 or N>CODE_DEPTH → ERROR. Otherwise latch N, clear the word index, byte index and checksum → DATA.
  - DATA: each accepted byte shifts into the word assembler and adds to the checksum.
    - On the 4th byte, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word; the word index then increments.
    - After word N-1 is written → CHECK.
  - CHECK: the received byte equals the checksum → DONE; otherwise → ERROR.
  - DONE: boot_done=1, cpu_rst=0 from the cycle after entry, rx_ready=0. Remains here until rst.
  - ERROR: boot_err=1, cpu_rst stays 1, rx_ready=1. A SYNC_BYTE → COUNT and clears boot_err; other bytes are discarded.
- Write latency: imem_we asserts 1 cycle after the 4th byte of a word is accepted.
- rx_ready stays 1 in every state except DONE, so the loader can accept back-to-back bytes every cycle. The write pulse never stalls input.
- Word data is written before the checksum is verified. A failed frame leaves partial contents in memory, but the CPU is never released on a failed frame.
- Addresses above N-1 are left untouched.
- rst asserted mid-frame: everything returns to reset values immediately. Instruction memory contents are not cleared.
- rx_valid while rx_ready=0 (DONE): ignored.

Optional Feature:
- Macro: BOOT_TIMEOUT_EN.
- Defined: a gap counter runs in COUNT, DATA and CHECK. It clears on every accepted byte. Reaching TIMEOUT_CYCLES forces ERROR, with boot_err=1 on the next cycle. The counter is idle in IDLE, DONE and ERROR.
- Undefined: no counter; the loader waits indefinitely for each byte.

Decomposition:
- Shared package:
  - state enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR).
  - SYNC_BYTE default.
  - instruction width constant (32).
- Natural sub-module: boot_word_assembler. It takes the 8-bit byte stream and outputs a 32-bit word, a 2-bit byte index, a word_valid pulse and the running checksum.
- The FSM, address counter and cpu_rst control stay in the top.

Test Plan:
- Good frame, N=2: send A5, 02, 20 01 00 05, 00 00 00 08, checksum 2E. Required: imem_we pulses with addr 0 / data 32'h20010005 and addr 1 / data 32'h00000008; boot_done=1; cpu_rst falls; rx_ready=0.
- Bad checksum: same frame with checksum 2F. Required: boot_err=1, cpu_rst=1, boot_done=0. A following good frame then succeeds and clears boot_err.
- Bad count byte:
  - 00 → ERROR, no imem_we.
  - 11 with CODE_DEPTH=16 → ERROR, no imem_we.
- Garbage before sync: send 00 FF 12, then a valid N=1 frame. Required: the leading bytes are ignored; a single write to addr 0.
- Reset mid-frame: assert rst after the 6th byte. Required: all outputs return to reset values; a fresh frame loads correctly.
- With BOOT_TIMEOUT_EN, TIMEOUT_CYCLES=20: stop after 3 data bytes. Required: boot_err=1 exactly 20 cycles after the last byte; no imem_we.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int         INSTR_W           = 32;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_boot_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words and keeps a modulo-256 byte sum.
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic [1:0]         byte_idx,
  output logic               word_valid,
  output logic [7:0]         checksum
);

  // Stage p1: word, index and sum update on each accepted byte; word_valid
  // is high for the single cycle after the fourth byte lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      byte_idx   <= 2'd0;
      word_valid <= 1'b0;
      checksum   <= 8'd0;
    end else begin
      word_valid <= byte_valid && (byte_idx == 2'd3);
      if (clear) begin
        byte_idx <= 2'd0;
        checksum <= 8'd0;
      end else if (byte_valid) begin
        word     <= {word[INSTR_W-9:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
        checksum <= checksum + byte_in;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: frames a byte stream into instruction-memory writes and holds
// the CPU in reset until a checksum-verified image is in place.
// Optional inter-byte gap timeout enabled by defining BOOT_TIMEOUT_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         CODE_DIR_WIDTH = 4,
  parameter int         CODE_DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      imem_we,
  output logic [CODE_DIR_WIDTH-1:0] imem_addr,
  output logic [INSTR_W-1:0]        imem_wdata,
  output logic                      cpu_rst,
  output logic                      boot_done,
  output logic                      boot_err
);

  localparam logic [CODE_DIR_WIDTH:0] ONE_N = 1;

  boot_state_t               state;
  logic [CODE_DIR_WIDTH:0]   count_n;
  logic [CODE_DIR_WIDTH-1:0] word_idx;
  logic                      accept;
  logic                      count_bad;
  logic                      last_word;
  logic                      asm_clear;
  logic                      asm_valid;
  logic [INSTR_W-1:0]        asm_word;
  logic [1:0]                asm_byte_idx;
  logic                      asm_word_valid;
  logic [7:0]                asm_checksum;
  logic                      timed_out;

  assign accept    = rx_valid && rx_ready;
  assign count_bad = (rx_data == 8'd0) || (int'(rx_data) > CODE_DEPTH);
  assign last_word = ({1'b0, word_idx} == (count_n - ONE_N));

  always_comb begin
    asm_clear = 1'b0;
    asm_valid = 1'b0;
    if (accept && (state == COUNT) && !count_bad) asm_clear = 1'b1;
    if (accept && (state == DATA))                asm_valid = 1'b1;
  end

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (asm_word),
    .byte_idx   (asm_byte_idx),
    .word_valid (asm_word_valid),
    .checksum   (asm_checksum)
  );

  // The write strobe and data come straight from the assembler's registers;
  // word_idx only advances after the strobe cycle, so the address is stable.
  assign imem_we    = asm_word_valid;
  assign imem_wdata = asm_word;
  assign imem_addr  = word_idx;

`ifdef BOOT_TIMEOUT_EN
  localparam int               GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] gap;
  logic             gap_active;

  assign gap_active = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign timed_out  = gap_active && !accept && (gap == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap <= '0;
    end else if (!gap_active || accept) begin
      gap <= '0;
    end else begin
      gap <= gap + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Stage p1: frame FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count_n   <= '0;
      word_idx  <= '0;
      rx_ready  <= 1'b1;
      cpu_rst   <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      if (asm_clear) begin
        word_idx <= '0;
      end else if (asm_word_valid) begin
        word_idx <= word_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept && (rx_data == SYNC_BYTE)) state <= COUNT;
        end
        COUNT: begin
          if (accept) begin
            if (count_bad) begin
              state    <= ERROR;
              boot_err <= 1'b1;
            end else begin
              count_n <= rx_data[CODE_DIR_WIDTH:0];
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && (asm_byte_idx == 2'd3) && last_word) state <= CHECK;
        end
        CHECK: begin
          if (accept) begin
            if (rx_data == asm_checksum) begin
              state     <= DONE;
              boot_done <= 1'b1;
              cpu_rst   <= 1'b0;
              rx_ready  <= 1'b0;
            end else begin
              state    <= ERROR;
              boot_err <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        ERROR: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            state    <= COUNT;
            boot_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (timed_out) begin
        state    <= ERROR;
        boot_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames
// checked against a frame-level model of expected writes and final status.
module tb_imem_boot_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TO    = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          boot_done;
  logic          boot_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc;

  logic [31:0]   fw[DEPTH];
  int            acc4[DEPTH];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];

  imem_boot_loader #(
    .CODE_DIR_WIDTH (AW),
    .CODE_DEPTH     (DEPTH),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    last_acc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad_sum, input int maxgap);
    int s;
    logic [7:0] b;
    s = 0;
    send_byte(8'hA5, int'($urandom_range(maxgap, 0)));
    send_byte(8'(n), int'($urandom_range(maxgap, 0)));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = fw[w][31-8*k -: 8];
        s = s + int'(b);
        send_byte(b, int'($urandom_range(maxgap, 0)));
        if (k == 3) acc4[w] = last_acc;
      end
    end
    b = 8'(s % 256);
    if (bad_sum) b = b + 8'd1;
    send_byte(b, int'($urandom_range(maxgap, 0)));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rx_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_cpurst: got rx_ready=%b cpu_rst=%b expected 1 1", rx_ready, cpu_rst);
    end
    n_cmp++;
    if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_imem: got we=%b addr=%h data=%h expected 0 0 0", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++;
    if (boot_done !== 1'b0 || boot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got done=%b err=%b expected 0 0", boot_done, boot_err);
    end
  endtask

  task automatic test_good_frame();
    apply_reset();
    fw[0] = 32'h20010005;
    fw[1] = 32'h00000008;
    send_frame(2, 1'b0, 0);
    n_cmp++;
    if (wr_addr_q.size() !== 2) begin
      n_fail++;
      $display("FAIL good_write_count: got %0d expected 2", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== fw[i] || wr_cyc_q[i] !== acc4[i]) begin
          n_fail++;
          $display("FAIL good_write%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], AW'(i), fw[i], acc4[i]);
        end
      end
    end
    n_cmp++;
    if (boot_done !== 1'b1 || cpu_rst !== 1'b0 || rx_ready !== 1'b0 || boot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL good_status: got done=%b cpu_rst=%b ready=%b err=%b expected 1 0 0 0",
               boot_done, cpu_rst, rx_ready, boot_err);
    end
    clear_log();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (6) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    n_cmp++;
    if (wr_addr_q.size() !== 0 || boot_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ignores_input: got writes=%0d done=%b cpu_rst=%b expected 0 1 0",
               wr_addr_q.size(), boot_done, cpu_rst);
    end
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    fw[0] = 32'h20010005;
    fw[1] = 32'h00000008;
    send_frame(2, 1'b1, 0);
    n_cmp++;
    if (boot_err !== 1'b1 || cpu_rst !== 1'b1 || boot_done !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL badsum_status: got err=%b cpu_rst=%b done=%b ready=%b expected 1 1 0 1",
               boot_err, cpu_rst, boot_done, rx_ready);
    end
    n_cmp++;
    if (wr_addr_q.size() !== 2) begin
      n_fail++;
      $display("FAIL badsum_partial_writes: got %0d expected 2", wr_addr_q.size());
    end
    clear_log();
    send_frame(2, 1'b0, 1);
    n_cmp++;
    if (boot_err !== 1'b0 || boot_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_after_badsum: got err=%b done=%b cpu_rst=%b expected 0 1 0",
               boot_err, boot_done, cpu_rst);
    end
  endtask

  task automatic test_bad_count();
    apply_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (boot_err !== 1'b1 || cpu_rst !== 1'b1 || wr_addr_q.size() !== 0) begin
      n_fail++;
      $display("FAIL count_zero: got err=%b cpu_rst=%b writes=%0d expected 1 1 0",
               boot_err, cpu_rst, wr_addr_q.size());
    end
    send_byte(8'hA5, 0);
    n_cmp++;
    if (boot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_clears_err: got err=%b expected 0", boot_err);
    end
    send_byte(8'h11, 0);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (boot_err !== 1'b1 || boot_done !== 1'b0 || wr_addr_q.size() !== 0) begin
      n_fail++;
      $display("FAIL count_over: got err=%b done=%b writes=%0d expected 1 0 0",
               boot_err, boot_done, wr_addr_q.size());
    end
  endtask

  task automatic test_garbage();
    apply_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h12, 0);
    n_cmp++;
    if (boot_err !== 1'b0 || boot_done !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL garbage_ignored: got err=%b done=%b cpu_rst=%b expected 0 0 1",
               boot_err, boot_done, cpu_rst);
    end
    fw[0] = $urandom();
    send_frame(1, 1'b0, 0);
    n_cmp++;
    if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== AW'(0) || wr_data_q[0] !== fw[0] || boot_done !== 1'b1) begin
      n_fail++;
      $display("FAIL garbage_then_frame: got writes=%0d data=%h done=%b expected 1 %h 1",
               wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, boot_done, fw[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(8'h11 * 8'(k + 1), 0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 || rx_ready !== 1'b1 ||
        cpu_rst !== 1'b1 || boot_done !== 1'b0 || boot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset_values: got we=%b addr=%h data=%h ready=%b cpu_rst=%b done=%b err=%b",
               imem_we, imem_addr, imem_wdata, rx_ready, cpu_rst, boot_done, boot_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (wr_addr_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midframe_no_write: got %0d expected 0", wr_addr_q.size());
    end
    fw[0] = $urandom();
    fw[1] = $urandom();
    send_frame(2, 1'b0, 0);
    n_cmp++;
    if (wr_addr_q.size() !== 2 || wr_data_q[0] !== fw[0] || wr_data_q[1] !== fw[1] ||
        wr_addr_q[1] !== AW'(1) || boot_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_fresh_frame: got writes=%0d done=%b expected 2 1", wr_addr_q.size(), boot_done);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) fw[i] = $urandom();
    send_frame(DEPTH, 1'b0, 0);
    n_cmp++;
    if (wr_addr_q.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d expected %0d", wr_addr_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== fw[i] || wr_cyc_q[i] !== acc4[i]) begin
          n_fail++;
          $display("FAIL b2b_write%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], AW'(i), fw[i], acc4[i]);
        end
      end
    end
    n_cmp++;
    if (boot_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_status: got done=%b cpu_rst=%b expected 1 0", boot_done, cpu_rst);
    end
  endtask

  task automatic test_random_frames();
    bit prev_done;
    apply_reset();
    prev_done = 1'b0;
    for (int it = 0; it < 12; it++) begin
      int n;
      bit bad_cnt, bad_sum, exp_done;
      logic [7:0] g;
      if (prev_done) apply_reset();
      clear_log();
      for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
        g = 8'($urandom_range(255, 0));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 0);
      end
      bad_cnt = ($urandom_range(4, 0) == 0);
      bad_sum = ($urandom_range(2, 0) == 0);
      if (bad_cnt) begin
        g = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, DEPTH + 1));
        send_byte(8'hA5, 0);
        send_byte(g, 1);
        repeat (2) begin @(posedge clk); #1; end
        n = 0;
        exp_done = 1'b0;
      end else begin
        n = int'($urandom_range(DEPTH, 1));
        for (int i = 0; i < n; i++) fw[i] = $urandom();
        send_frame(n, bad_sum, 2);
        exp_done = !bad_sum;
      end
      n_cmp++;
      if (wr_addr_q.size() !== n) begin
        n_fail++;
        $display("FAIL rand%0d_write_count: got %0d expected %0d", it, wr_addr_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== fw[i] || wr_cyc_q[i] !== acc4[i]) begin
            n_fail++;
            $display("FAIL rand%0d_write%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                     it, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], AW'(i), fw[i], acc4[i]);
          end
        end
      end
      n_cmp++;
      if (boot_done !== exp_done || boot_err !== !exp_done || cpu_rst !== !exp_done || rx_ready !== !exp_done) begin
        n_fail++;
        $display("FAIL rand%0d_status: got done=%b err=%b cpu_rst=%b ready=%b expected done=%b",
                 it, boot_done, boot_err, cpu_rst, rx_ready, exp_done);
      end
      prev_done = exp_done;
    end
  endtask

`ifdef BOOT_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(255, 0)), 0);
    for (int k = 1; k <= TO + 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (boot_err !== (k >= TO)) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got err=%b expected %b", k, boot_err, (k >= TO));
      end
    end
    n_cmp++;
    if (wr_addr_q.size() !== 0 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_no_write: got writes=%0d cpu_rst=%b expected 0 1", wr_addr_q.size(), cpu_rst);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    test_reset();
    rst = 1'b0;
    test_good_frame();
    test_bad_checksum();
    test_bad_count();
    test_garbage();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
`ifdef BOOT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
